// File: rtl/noc_router_network.sv
`default_nettype none
// ============================================================================
//  Module   : noc_router_network
//  Purpose  : 13-port single-hop packet crossbar. Each input has a one-entry
//             holding slot, each output has a round-robin arbiter and a
//             registered output slot.
//  Revision : 1.0 - initial release
// ============================================================================
module noc_router_network #(
    parameter int WIDTH_PACKAGE = 33,
    parameter int NUM_PM        = 13,
    parameter int DEST_LSB      = 29
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PM*WIDTH_PACKAGE-1:0] pm_in_data,
    input  logic [NUM_PM-1:0]               pm_in_valid,
    output logic [NUM_PM-1:0]               pm_in_ready,
    output logic [NUM_PM*WIDTH_PACKAGE-1:0] pm_out_data,
    output logic [NUM_PM-1:0]               pm_out_valid,
    input  logic [NUM_PM-1:0]               pm_out_ready
);

    localparam int c_dest_w = WIDTH_PACKAGE - DEST_LSB;
    localparam int c_ptr_w  = 4;

    logic [NUM_PM-1:0]        slot_vld_q;
    logic [WIDTH_PACKAGE-1:0] slot_dat_q [NUM_PM];
    logic [NUM_PM-1:0]        out_vld_q;
    logic [WIDTH_PACKAGE-1:0] out_dat_q  [NUM_PM];
    logic [c_ptr_w-1:0]       ptr_q      [NUM_PM];
    logic [c_ptr_w-1:0]       ptr_d      [NUM_PM];
    logic                     en_q;

    logic [c_dest_w-1:0]      w_dest     [NUM_PM];
    logic [NUM_PM-1:0]        w_req;
    logic [NUM_PM-1:0]        w_drop;
    logic [NUM_PM-1:0]        w_gnt_vld;
    logic [c_ptr_w-1:0]       w_gnt_idx  [NUM_PM];
    logic [NUM_PM-1:0]        w_leave;

    generate
        for (genvar i = 0; i < NUM_PM; i++) begin : g_port
            assign w_dest[i] = slot_dat_q[i][WIDTH_PACKAGE-1:DEST_LSB];
            assign w_req[i]  = slot_vld_q[i] && (w_dest[i] <= c_dest_w'(NUM_PM - 1));
            assign w_drop[i] = slot_vld_q[i] && (w_dest[i] >  c_dest_w'(NUM_PM - 1));
            assign pm_out_data[i*WIDTH_PACKAGE +: WIDTH_PACKAGE] = out_dat_q[i];
        end
    endgenerate

    assign pm_out_valid = out_vld_q;

    // Scan cyclically starting just after the pointer; first match wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < NUM_PM; j++) begin
            w_gnt_vld[j] = 1'b0;
            w_gnt_idx[j] = '0;
            ptr_d[j]     = ptr_q[j];
            if (!out_vld_q[j] || pm_out_ready[j]) begin
                for (int k = 1; k <= NUM_PM; k++) begin
                    idx = (int'(ptr_q[j]) + k) % NUM_PM;
                    if (!w_gnt_vld[j] && w_req[idx] &&
                        (w_dest[idx] == c_dest_w'(j))) begin
                        w_gnt_vld[j] = 1'b1;
                        w_gnt_idx[j] = c_ptr_w'(idx);
                    end
                end
                if (w_gnt_vld[j]) begin
                    ptr_d[j] = w_gnt_idx[j];
                end
            end
        end
    end

    always_comb begin
        w_leave = w_drop;
        for (int j = 0; j < NUM_PM; j++) begin
            if (w_gnt_vld[j]) begin
                w_leave[w_gnt_idx[j]] = 1'b1;
            end
        end
    end

    // en_q keeps ready low until the first edge after reset release.
    assign pm_in_ready = {NUM_PM{en_q}} & (~slot_vld_q | w_leave);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            slot_vld_q <= '0;
            out_vld_q  <= '0;
            for (int i = 0; i < NUM_PM; i++) begin
                slot_dat_q[i] <= '0;
                out_dat_q[i]  <= '0;
                ptr_q[i]      <= c_ptr_w'(NUM_PM - 1);
            end
        end else begin
            en_q <= 1'b1;
            for (int i = 0; i < NUM_PM; i++) begin
                if (pm_in_valid[i] && pm_in_ready[i]) begin
                    slot_vld_q[i] <= 1'b1;
                    slot_dat_q[i] <= pm_in_data[i*WIDTH_PACKAGE +: WIDTH_PACKAGE];
                end else if (w_leave[i]) begin
                    slot_vld_q[i] <= 1'b0;
                end
            end
            for (int j = 0; j < NUM_PM; j++) begin
                ptr_q[j] <= ptr_d[j];
                if (w_gnt_vld[j]) begin
                    out_vld_q[j] <= 1'b1;
                    out_dat_q[j] <= slot_dat_q[w_gnt_idx[j]];
                end else if (pm_out_ready[j]) begin
                    out_vld_q[j] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_router_network.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_router_network
//  Purpose  : Directed self-checking bench for noc_router_network plus a
//             scoreboarded random soak.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_router_network;

    localparam int W  = 33;
    localparam int NP = 13;
    localparam int N_SOAK = 80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*W-1:0]   in_data;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*W-1:0]   out_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    noc_router_network dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pm_in_data   (in_data),
        .pm_in_valid  (in_valid),
        .pm_in_ready  (in_ready),
        .pm_out_data  (out_data),
        .pm_out_valid (out_valid),
        .pm_out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mkpkt(input int dest, input int src, input int seq);
        return {4'(dest), 29'((src << 16) | seq)};
    endfunction

    function automatic logic [W-1:0] get_out(input int j);
        return out_data[j*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int src, input logic [W-1:0] pkt);
        in_data[src*W +: W] = pkt;
        in_valid[src]       = 1'b1;
    endtask

    logic [W-1:0] exp_q [NP*NP][$];
    logic [W-1:0] p [3];
    logic [W-1:0] pa, pb, pc, pd, pk;
    logic [NP-1:0] seen, acc;
    int sent [NP];
    int n_rx, left, src;

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = '1;

        // Reset state
        #2;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data[63:0], 0);
        check_eq("rst_in_ready", in_ready, 0);
        tick();
        check_eq("rst_in_ready_edge", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", in_ready, 13'h1fff);

        // Single packet PM3 -> 7
        pa = {4'd7, 29'h1ABCDEF};
        send(3, pa);
        #1;
        check_eq("single_rdy", in_ready[3], 1);
        tick();
        in_valid = '0;
        check_eq("single_lat_k", out_valid, 0);
        tick();
        check_eq("single_valid", out_valid, 13'h0080);
        check_eq("single_data", get_out(7), pa);
        tick();
        check_eq("single_drain", out_valid, 0);

        // Contention on output 4, two bursts
        for (int b = 1; b <= 2; b++) begin
            p[0] = mkpkt(4, 0, b);
            p[1] = mkpkt(4, 5, b);
            p[2] = mkpkt(4, 12, b);
            send(0, p[0]); send(5, p[1]); send(12, p[2]);
            tick();
            in_valid = '0;
            for (int r = 0; r < 3; r++) begin
                tick();
                check_eq("cont_valid", out_valid, 13'h0010);
                check_eq("cont_data", get_out(4), p[r]);
            end
            tick();
            check_eq("cont_drain", out_valid, 0);
        end

        // Backpressure on output 2
        out_ready    = '1;
        out_ready[2] = 1'b0;
        pa = mkpkt(2, 1, 1);
        pb = mkpkt(2, 1, 2);
        pc = mkpkt(9, 6, 1);
        send(1, pa); send(6, pc);
        tick();
        in_valid[6] = 1'b0;
        in_data[1*W +: W] = pb;
        #1;
        check_eq("bp_rdy_grant", in_ready[1], 1);
        tick();
        in_valid[1] = 1'b0;
        #1;
        check_eq("bp_valid2", out_valid, 13'h0204);
        check_eq("bp_data2", get_out(2), pa);
        check_eq("bp_data9", get_out(9), pc);
        check_eq("bp_rdy_blocked", in_ready[1], 0);
        tick();
        check_eq("bp_hold_valid", out_valid, 13'h0004);
        check_eq("bp_hold_data", get_out(2), pa);
        check_eq("bp_rdy_still", in_ready[1], 0);
        out_ready[2] = 1'b1;
        #1;
        check_eq("bp_rdy_release", in_ready[1], 1);
        tick();
        check_eq("bp_second_valid", out_valid, 13'h0004);
        check_eq("bp_second_data", get_out(2), pb);
        tick();
        check_eq("bp_drain", out_valid, 0);

        // Illegal destination from PM8
        send(8, mkpkt(14, 8, 1));
        #1;
        check_eq("ill_rdy_accept", in_ready[8], 1);
        tick();
        pd = mkpkt(0, 8, 2);
        in_data[8*W +: W] = pd;
        #1;
        check_eq("ill_rdy_drop", in_ready[8], 1);
        tick();
        in_valid = '0;
        check_eq("ill_no_out", out_valid, 0);
        tick();
        check_eq("ill_next_valid", out_valid, 13'h0001);
        check_eq("ill_next_data", get_out(0), pd);
        tick();

        // Reset in mid-operation
        out_ready = '0;
        send(2, mkpkt(5, 2, 1)); send(9, mkpkt(10, 9, 1));
        tick();
        in_valid[9] = 1'b0;
        in_data[2*W +: W] = mkpkt(5, 2, 2);
        tick();
        in_valid = '0;
        #1;
        check_eq("mid_pre", out_valid, 13'h0420);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_ready", in_ready, 0);
        check_eq("mid_rst_data", {out_data[10*W +: W], out_data[5*W +: W]}, 0);
        #1;
        rst_n     = 1'b1;
        out_ready = '1;
        seen = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen |= out_valid;
        end
        check_eq("mid_no_stale", seen, 0);
        check_eq("mid_ready_back", in_ready, 13'h1fff);

        // Random soak with per-(source,dest) scoreboard
        acc  = '0;
        n_rx = 0;
        for (int i = 0; i < NP; i++) sent[i] = 0;
        for (int cyc = 0; cyc < 20000 && n_rx < NP * N_SOAK; cyc++) begin
            for (int i = 0; i < NP; i++) begin
                if (!(in_valid[i] && !acc[i])) begin
                    if (sent[i] < N_SOAK && $urandom_range(3) != 0)
                        send(i, mkpkt($urandom_range(11), i, sent[i] + 1));
                    else
                        in_valid[i] = 1'b0;
                end
                out_ready[i] = ($urandom_range(3) != 0);
            end
            @(negedge clk);
            acc = in_valid & in_ready;
            for (int i = 0; i < NP; i++) begin
                if (acc[i]) begin
                    pk = in_data[i*W +: W];
                    exp_q[i*NP + int'(pk[32:29])].push_back(pk);
                    sent[i]++;
                end
            end
            for (int j = 0; j < NP; j++) begin
                if (out_valid[j] && out_ready[j]) begin
                    pk  = get_out(j);
                    src = int'(pk[19:16]);
                    n_rx++;
                    if (src < NP && exp_q[src*NP + j].size() > 0)
                        check_eq("soak_data", pk, exp_q[src*NP + j].pop_front());
                    else
                        check_eq("soak_unexpected", pk, 0);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        left = 0;
        for (int k = 0; k < NP * NP; k++) left += exp_q[k].size();
        check_eq("soak_count", n_rx, NP * N_SOAK);
        check_eq("soak_leftover", left, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
